// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 4-digit multiplexed seven-segment scan controller with frame-synchronous loads.
// Optional per-digit blinking is compiled in when SEG_SCAN_BLINK_EN is defined.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 4
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lz_blank,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [3:0]  blink_mask,
`endif
  output logic        load_ack,
  output logic [3:0]  digit,
  output logic [3:0]  anode,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pending_valid;
  logic          blank;

  logic          frame_end;
  logic          commit;
  logic [1:0]    next_slot;
  logic [15:0]   next_active;
  logic [3:0]    next_nibble;
  logic          next_blank;
  logic          zero3, zero2, zero1;
  logic          blink_blank;

  assign frame_end = enable && (state == ST_DRIVE) && (cnt == SLOT_LAST) && (slot == 2'd3);
  assign commit    = pending_valid && (frame_end || (state == ST_OFF));
  assign dp        = 1'b1;

  // Digit and blanking for the slot being entered; a commit on this edge is already visible.
  always_comb begin
    next_slot   = (state == ST_OFF) ? 2'd0 : slot + 2'd1;
    next_active = commit ? pending : active;
    next_nibble = next_active[4*next_slot +: 4];
    zero3       = (next_active[15:12] == 4'd0);
    zero2       = zero3 && (next_active[11:8] == 4'd0);
    zero1       = zero2 && (next_active[7:4] == 4'd0);
    next_blank  = (next_nibble > 4'd9);
    if (lz_blank) begin
      case (next_slot)
        2'd3:    next_blank = next_blank | zero3;
        2'd2:    next_blank = next_blank | zero2;
        2'd1:    next_blank = next_blank | zero1;
        default: next_blank = next_blank;
      endcase
    end
  end

  always_comb begin
    anode = 4'b1111;
    if ((state == ST_DRIVE) && !blank && !blink_blank) anode[slot] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_OFF;
      cnt           <= '0;
      slot          <= 2'd0;
      active        <= 16'h0;
      pending       <= 16'h0;
      pending_valid <= 1'b0;
      load_ack      <= 1'b0;
      digit         <= 4'h0;
      blank         <= 1'b0;
    end else begin
      load_ack <= commit;
      if (commit) active <= pending;
      // A load coinciding with a commit becomes the next pending value.
      if (load) begin
        pending       <= value;
        pending_valid <= 1'b1;
      end else if (commit) begin
        pending_valid <= 1'b0;
      end

      if (!enable) begin
        state <= ST_OFF;
        cnt   <= '0;
        slot  <= 2'd0;
      end else begin
        case (state)
          ST_OFF: begin
            state <= ST_GUARD;
            cnt   <= '0;
            slot  <= 2'd0;
            digit <= next_nibble;
            blank <= next_blank;
          end
          ST_GUARD: begin
            if (cnt == GUARD_LAST) state <= ST_DRIVE;
            cnt <= cnt + CNT_ONE;
          end
          ST_DRIVE: begin
            if (cnt == SLOT_LAST) begin
              state <= ST_GUARD;
              cnt   <= '0;
              slot  <= next_slot;
              digit <= next_nibble;
              blank <= next_blank;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_OFF;
            cnt   <= '0;
            slot  <= 2'd0;
          end
        endcase
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);

  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!enable || (state == ST_OFF)) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FRAME_ONE;
      end
    end
  end

  assign blink_blank = blink_phase && blink_mask[slot];
`else
  assign blink_blank = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scoreboard bench for seven_seg_scanner with REFRESH_DIV=8, GUARD_CYCLES=2.
// Define SEG_SCAN_BLINK_EN to also exercise blinking with BLINK_FRAMES=2.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic        lz_blank;
  logic [3:0]  blink_mask;
  logic        load_ack;
  logic [3:0]  digit;
  logic [3:0]  anode;
  logic        dp;

  int checks = 0;
  int failures = 0;
  int ticks = 0;
  int scan_c = -1;
  int load_tick = 0;
  int acks = 0;
  logic [15:0] disp_val = 16'h0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .REFRESH_DIV (8),
    .GUARD_CYCLES(2)
`ifdef SEG_SCAN_BLINK_EN
    ,
    .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .load    (load),
    .value   (value),
    .lz_blank(lz_blank),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .load_ack(load_ack),
    .digit   (digit),
    .anode   (anode),
    .dp      (dp)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_blank(input logic [15:0] v, input int s, input logic lz);
    if (v[4*s +: 4] > 4'd9) return 1'b1;
    if (lz && s > 0) begin
      for (int i = s; i < 4; i++) if (v[4*i +: 4] != 4'd0) return 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock of observation: advance the expected scan position and compare every output.
  task automatic tick();
    logic [3:0] exp_an;
    logic       bl;
    int         s, k, f;
    @(negedge clk);
    ticks++;
    if (enable) scan_c++;
    else scan_c = -1;
    if (load_ack === 1'b1) begin
      acks++;
      if (exp_q.size() == 0) check_output("spurious_ack", 1, 0);
      else begin
        disp_val = exp_q.pop_front();
        if (scan_c >= 0) check_output("ack_at_frame_start", scan_c % 32, 0);
        else check_output("ack_latency_off", ticks - load_tick, 2);
      end
    end
    exp_an = 4'b1111;
    if (scan_c >= 0) begin
      s  = (scan_c / 8) % 4;
      k  = scan_c % 8;
      f  = scan_c / 32;
      bl = exp_blank(disp_val, s, lz_blank);
`ifdef SEG_SCAN_BLINK_EN
      if (((f / 2) % 2) == 1 && blink_mask[s]) bl = 1'b1;
`endif
      if (k >= 2 && !bl) exp_an[s] = 1'b0;
      check_output("digit", digit, disp_val[4*s +: 4]);
    end
    check_output("anode", anode, exp_an);
    check_output("dp", dp, 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < 64 && (scan_c % 32) != phase; i++) tick();
  endtask

  // Drive a one-cycle load and record the value the display should eventually commit.
  task automatic apply_stimulus(input logic [15:0] v);
    load_tick = ticks;
    load  = 1'b1;
    value = v;
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = v;
    else exp_q.push_back(v);
    tick();
    load = 1'b0;
  endtask

  initial begin
    int acks0;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = 16'h0;
    lz_blank = 1'b0; blink_mask = 4'b0000;
    #1;
    check_output("reset_anode", anode, 4'b1111);
    check_output("reset_digit", digit, 4'h0);
    check_output("reset_ack", load_ack, 0);
    check_output("reset_dp", dp, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(6);
    check_output("idle_digit", digit, 4'h0);

    $display("[TB] scan order");
    apply_stimulus(16'h1234);
    run(3);
    check_output("drained_1234", exp_q.size(), 0);
    enable = 1'b1;
    run(64);

    $display("[TB] frame-synchronous commit");
    run_to(10);
    apply_stimulus(16'h5678);
    run(40);
    check_output("drained_5678", exp_q.size(), 0);

    $display("[TB] load overwrite");
    run_to(4);
    acks0 = acks;
    apply_stimulus(16'h1111);
    run_to(20);
    apply_stimulus(16'h2222);
    run(48);
    check_output("single_ack", acks - acks0, 1);
    check_output("drained_2222", exp_q.size(), 0);

    $display("[TB] leading zeros and invalid nibbles");
    enable = 1'b0;
    run(2);
    lz_blank = 1'b1;
    apply_stimulus(16'h0040);
    run(3);
    enable = 1'b1;
    run(40);
    enable = 1'b0;
    run(2);
    apply_stimulus(16'h0000);
    run(3);
    enable = 1'b1;
    run(40);
    enable = 1'b0;
    run(2);
    lz_blank = 1'b0;
    apply_stimulus(16'h0A12);
    run(3);
    enable = 1'b1;
    run(40);
    check_output("drained_lz", exp_q.size(), 0);

    $display("[TB] reset mid-drive");
    run_to(3);
    apply_stimulus(16'h9999);
    run_to(5);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_anode", anode, 4'b1111);
    check_output("async_reset_digit", digit, 4'h0);
    check_output("async_reset_ack", load_ack, 0);
    exp_q.delete();
    disp_val = 16'h0;
    enable   = 1'b0;
    scan_c   = -1;
    @(negedge clk);
    rst_n = 1'b1;
    run(6);
    enable = 1'b1;
    run(40);

`ifdef SEG_SCAN_BLINK_EN
    $display("[TB] blink");
    enable = 1'b0;
    run(2);
    blink_mask = 4'b0001;
    apply_stimulus(16'h1234);
    run(3);
    enable = 1'b1;
    run(6 * 32);
    check_output("drained_blink", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Holds a 16-bit packed BCD value and rotates through the four digits, driving one active-low anode at a time.
- Presents the selected 4-bit digit code to the existing BCD-to-cathode decoder.
- Provides a frame-synchronous load handshake so the game logic never tears a displayed number, plus optional leading-zero blanking and guard (ghosting-suppression) intervals.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz/digit at 100 MHz); legal range 4..2^20.
- GUARD_CYCLES, 4, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  1 = scanning; 0 = display dark
- load  input  1  one-cycle strobe: capture value into pending register
- value  input  16  packed BCD; [3:0] = digit0 (rightmost) .. [15:12] = digit3
- lz_blank  input  1  1 = suppress leading zeros
- load_ack  output  1  one-cycle pulse when the pending value becomes active
- digit  output  4  BCD code to cathode decoder for current slot
- anode  output  4  active-low anode enables; bit i = digit i
- dp  output  1  decimal point, active low; constant 1 (off)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset values:
  - anode=4'b1111, digit=4'h0, load_ack=0, dp=1.
  - Active and pending registers = 16'h0; pending_valid=0.
  - slot=0, slot counter=0, state=OFF.
- States:
  - OFF: anode=1111, counter and slot held at 0.
  - GUARD: anode=1111, digit already driven with the new slot's nibble so the decoder settles.
  - DRIVE: anode[slot]=0 unless blanked.
- Transitions:
  - OFF -> GUARD when enable=1.
  - GUARD -> DRIVE after GUARD_CYCLES cycles.
  - DRIVE -> GUARD after REFRESH_DIV-GUARD_CYCLES cycles; slot increments 0->1->2->3->0 (2-bit wrap).
  - Any state -> OFF within one cycle of enable=0; slot and counter reset to 0.
- Frame length is exactly 4*REFRESH_DIV cycles. A frame boundary is the cycle on which slot 3 DRIVE ends (the transition into slot 0 GUARD).
- Load handshake:
  - load=1 captures value into pending and sets pending_valid on the next edge.
  - A second load before commit overwrites pending (last wins); no ack for the overwritten value.
  - Commit (active<=pending, pending_valid<=0, load_ack=1 for one cycle) occurs at the next frame boundary.
  - In OFF, commit occurs on the cycle after capture.
  - load on the same cycle as a commit: the commit uses the old pending value, and the new value becomes pending with pending_valid=1.
- Digit selection: digit = active[4*slot+3 : 4*slot], registered and updated on entry to GUARD.
- Blanking (anode held 1 during DRIVE):
  - Any nibble > 9 is blanked.
  - When lz_blank=1, digit i (i=3..1) is blanked if it and all higher digits are 0. Digit0 is never lz-blanked (value 0 shows "0").
  - lz_blank is sampled continuously; a change takes effect at the next GUARD entry.
- Counter width = clog2(REFRESH_DIV); no other arithmetic.
- Reset mid-scan: immediate return to reset values; pending load discarded, no load_ack.

Optional Feature:
- Macro SEG_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask[3:0] and parameter BLINK_FRAMES (default 250).
  - A frame counter toggles blink_phase every BLINK_FRAMES frames; blink_phase resets to 0.
  - When blink_phase=1, digits with blink_mask[i]=1 are blanked in DRIVE.
  - The frame counter and blink_phase clear in OFF.
- Undefined: no blink_mask port, no frame counter; behaviour as above.

Test Plan:
- All scenarios use REFRESH_DIV=8, GUARD_CYCLES=2.
- Reset/idle: rst_n=0 then release, enable=0 -> anode=1111, digit=0, load_ack never pulses; assert rst_n mid-DRIVE -> anode=1111 asynchronously.
- Scan order: load 16'h1234 in OFF, then enable=1 -> load_ack one cycle after capture. Each 8-cycle slot has anode=1111 for 2 cycles, then anode=1110/1101/1011/0111 for 6 cycles with digit=4/3/2/1; period 32 cycles.
- Frame-synchronous commit: while scanning 16'h1234, load 16'h5678 during slot 1 -> digits unchanged through slot 3. load_ack pulses at the slot3->slot0 boundary, and the next slot 0 shows digit=8.
- Load overwrite: load 16'h1111 then 16'h2222 in the same frame -> single load_ack; 2222 displayed.
- Leading zeros: value 16'h0040, lz_blank=1 -> anode stays 1111 in slots 3 and 2, active in slots 1 and 0. value 16'h0000 -> only slot 0 lit, digit=0. Nibble 4'hA in slot 2 -> slot 2 dark.
- Blink (SEG_SCAN_BLINK_EN, BLINK_FRAMES=2, blink_mask=0001): slot 0 lit for frames 0-1, dark for frames 2-3, lit for frames 4-5; other slots always lit.
